pwm_multicanal: RTL and testbench

Parametrised multi-channel PWM generator, the successor to the single-channel basic PWM block. It drives N independent PWM outputs from one shared prescaled period counter. Each channel has a per-channel duty register that is double-buffered: writes land in a shadow register and become active only at the period boundary. Both edge-aligned and center-aligned modes are supported. A one-cycle `enable` pulse at each period start lets downstream logic (sequencers, ADC triggers) synchronise to the PWM frame.

---
 rtl/pwm_multicanal.sv | 131 +++++++++++++
 tb/tb_pwm_multicanal.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multicanal.sv
// pwm_multicanal: N-channel PWM generator sharing one prescaled period counter.
// Per-channel duties are double-buffered (shadow -> active at the period boundary),
// with edge-aligned and center-aligned counting and a frame-start enable pulse.
module pwm_multicanal #(
    parameter  int unsigned R  = 8,
    parameter  int unsigned N  = 4,
    parameter  int unsigned PW = 10,
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          mode,
    input  logic [PW-1:0] prescale,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_ch,
    input  logic [R-1:0]  wr_duty,
    output logic          enable,
    output logic [N-1:0]  pwm_out
);

    localparam logic [R-1:0] MAX      = {R{1'b1}};
    localparam logic [R-1:0] ONE      = R'(1);
    localparam logic [0:0]   DIR_UP   = 1'b0;
    localparam logic [0:0]   DIR_DOWN = 1'b1;

    logic [PW-1:0]       pre_cnt;
    logic [PW-1:0]       pre_nx;
    logic [R-1:0]        cnt;
    logic [R-1:0]        cnt_nx;
    logic [0:0]          dir;
    logic [0:0]          dir_nx;
    logic                act_mode;
    logic                mode_nx;
    logic [N-1:0][R-1:0] shadow;
    logic [N-1:0][R-1:0] shadow_nx;
    logic [N-1:0][R-1:0] active;
    logic [N-1:0][R-1:0] active_nx;
    logic                period_start;
    logic                tick;
    logic                boundary;
    logic                wr_hit;
    logic                load;
    logic [N-1:0]        pwm_nx;

    // Prescaler tick and period-boundary detection for the active counting mode
    always_comb begin
        tick     = run && (pre_cnt >= prescale);
        boundary = 1'b0;
        if (act_mode) begin
            boundary = tick && (dir == DIR_DOWN) && (cnt == ONE);
        end else begin
            boundary = tick && (cnt == MAX);
        end
    end

    // Next prescaler, period counter and direction
    always_comb begin
        pre_nx = pre_cnt;
        cnt_nx = cnt;
        dir_nx = dir;
        if (!run || tick) begin
            pre_nx = '0;
        end else begin
            pre_nx = pre_cnt + PW'(1);
        end
        if (!run || boundary) begin
            cnt_nx = '0;
            dir_nx = DIR_UP;
        end else if (tick) begin
            if (!act_mode) begin
                cnt_nx = cnt + ONE;
            end else if (dir == DIR_UP) begin
                if (cnt == MAX) begin
                    cnt_nx = MAX - ONE;
                    dir_nx = DIR_DOWN;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end else begin
                cnt_nx = cnt - ONE;
            end
        end
    end

    // Shadow writes, forwarded into the active set whenever it reloads
    always_comb begin
        wr_hit    = wr_en && (32'(wr_ch) < N);
        load      = boundary || !run;
        shadow_nx = shadow;
        if (wr_hit) begin
            shadow_nx[wr_ch] = wr_duty;
        end
        active_nx = load ? shadow_nx : active;
        mode_nx   = load ? mode : act_mode;
    end

    // Per-channel compare against the shared counter
    always_comb begin
        pwm_nx = '0;
        for (int i = 0; i < N; i++) begin
            pwm_nx[i] = run && (cnt < active[i]);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt      <= '0;
            cnt          <= '0;
            dir          <= DIR_UP;
            act_mode     <= 1'b0;
            shadow       <= '0;
            active       <= '0;
            period_start <= 1'b0;
            enable       <= 1'b0;
            pwm_out      <= '0;
        end else begin
            pre_cnt      <= pre_nx;
            cnt          <= cnt_nx;
            dir          <= dir_nx;
            act_mode     <= mode_nx;
            shadow       <= shadow_nx;
            active       <= active_nx;
            period_start <= boundary;
            enable       <= period_start && run;
            pwm_out      <= pwm_nx;
        end
    end

endmodule

// File: tb/tb_pwm_multicanal.sv
// Directed bench for pwm_multicanal (R=4, N=4): period lengths, high times and
// enable placement are counted at the falling edge and compared with hand values.
module tb_pwm_multicanal;

    localparam int unsigned R  = 4;
    localparam int unsigned N  = 4;
    localparam int unsigned PW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          mode;
    logic [PW-1:0] prescale;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [R-1:0]  wr_duty;
    logic          enable;
    logic [N-1:0]  pwm_out;

    int errors = 0;
    int checks = 0;
    int per_len;
    int hi_cnt [4];

    pwm_multicanal #(.R(R), .N(N), .PW(PW)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .mode     (mode),
        .prescale (prescale),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_duty  (wr_duty),
        .enable   (enable),
        .pwm_out  (pwm_out)
    );

    always #5 clk = ~clk;

    // One clock: inputs change and outputs are sampled at the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance until an enable sample, bounded
    task automatic wait_enable(input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            step();
            if (enable) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_enable: got no pulse within %0d clocks, expected one", budget);
        end
    endtask

    // Count samples and per-channel high samples from now until the next enable,
    // optionally writing a duty or changing prescale at a given sample index
    task automatic measure(input int wr_idx, input logic [1:0] wch, input logic [R-1:0] wd,
                           input int ps_idx, input logic [PW-1:0] ps_val);
        per_len = 0;
        for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 4; i++) if (pwm_out[i]) hi_cnt[i]++;
            per_len++;
            if (k == wr_idx) begin
                wr_en   = 1'b1;
                wr_ch   = wch;
                wr_duty = wd;
            end
            if (k == ps_idx) prescale = ps_val;
            step();
            wr_en = 1'b0;
            if (enable) return;
        end
        per_len = -1;
    endtask

    task automatic write_duty(input logic [1:0] ch, input logic [R-1:0] d);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_duty = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if (pwm_out !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pwm: got %b expected 0000", pwm_out);
        end
        checks++;
        if (enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_enable: got %b expected 0", enable);
        end
        reset = 1'b1;
        step();
        for (int p = 0; p < 2; p++) begin
            measure(-1, 2'd0, '0, -1, '0);
            checks++;
            if (per_len !== 16) begin
                errors++;
                $display("FAIL idle_period%0d: got %0d expected 16", p, per_len);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (hi_cnt[i] !== 0) begin
                    errors++;
                    $display("FAIL idle_high ch%0d: got %0d expected 0", i, hi_cnt[i]);
                end
            end
        end
    endtask

    task automatic test_edge();
        int exp_hi [4] = '{4, 15, 0, 8};
        write_duty(2'd0, 4'd4);
        write_duty(2'd1, 4'd15);
        write_duty(2'd2, 4'd0);
        write_duty(2'd3, 4'd8);
        wait_enable(40);
        checks++;
        if (pwm_out !== 4'b1011) begin
            errors++;
            $display("FAIL edge_rise: got %b expected 1011", pwm_out);
        end
        measure(-1, 2'd0, '0, -1, '0);
        checks++;
        if (per_len !== 16) begin
            errors++;
            $display("FAIL edge_period: got %0d expected 16", per_len);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (hi_cnt[i] !== exp_hi[i]) begin
                errors++;
                $display("FAIL edge_high ch%0d: got %0d expected %0d", i, hi_cnt[i], exp_hi[i]);
            end
        end
    endtask

    task automatic test_double_buffer();
        int           widx [4] = '{0, 0, 14, -1};
        logic [R-1:0] wd   [4] = '{4'd10, 4'd4, 4'd10, 4'd0};
        int           exp0 [4] = '{4, 10, 4, 10};
        for (int j = 0; j < 4; j++) begin
            measure(widx[j], 2'd0, wd[j], -1, '0);
            checks++;
            if (per_len !== 16) begin
                errors++;
                $display("FAIL dbuf_period%0d: got %0d expected 16", j, per_len);
            end
            checks++;
            if (hi_cnt[0] !== exp0[j]) begin
                errors++;
                $display("FAIL dbuf_high%0d: got %0d expected %0d", j, hi_cnt[0], exp0[j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        write_duty(2'd1, 4'd3);
        write_duty(2'd1, 4'd5);
        write_duty(2'd1, 4'd7);
        wait_enable(40);
        measure(-1, 2'd0, '0, -1, '0);
        checks++;
        if (hi_cnt[1] !== 7) begin
            errors++;
            $display("FAIL b2b_last_wins: got %0d expected 7", hi_cnt[1]);
        end
        checks++;
        if (hi_cnt[0] !== 10) begin
            errors++;
            $display("FAIL b2b_other_ch: got %0d expected 10", hi_cnt[0]);
        end
    endtask

    task automatic test_center();
        int exp_hi [4] = '{9, 13, 0, 15};
        mode = 1'b1;
        write_duty(2'd0, 4'd5);
        wait_enable(40);
        checks++;
        if (pwm_out !== 4'b1011) begin
            errors++;
            $display("FAIL center_start: got %b expected 1011", pwm_out);
        end
        for (int p = 0; p < 2; p++) begin
            measure(-1, 2'd0, '0, -1, '0);
            checks++;
            if (per_len !== 30) begin
                errors++;
                $display("FAIL center_period%0d: got %0d expected 30", p, per_len);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (hi_cnt[i] !== exp_hi[i]) begin
                errors++;
                $display("FAIL center_high ch%0d: got %0d expected %0d", i, hi_cnt[i], exp_hi[i]);
            end
        end
    endtask

    task automatic test_prescale();
        int exp_hi [4] = '{12, 21, 0, 24};
        mode     = 1'b0;
        prescale = 10'd2;
        write_duty(2'd0, 4'd4);
        wait_enable(300);
        measure(-1, 2'd0, '0, -1, '0);
        checks++;
        if (per_len !== 48) begin
            errors++;
            $display("FAIL presc_period: got %0d expected 48", per_len);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (hi_cnt[i] !== exp_hi[i]) begin
                errors++;
                $display("FAIL presc_high ch%0d: got %0d expected %0d", i, hi_cnt[i], exp_hi[i]);
            end
        end
        // prescale drops to 0 while the prescaler sits at 2
        measure(-1, 2'd0, '0, 1, 10'd0);
        checks++;
        if (per_len !== 18) begin
            errors++;
            $display("FAIL presc_drop_period: got %0d expected 18", per_len);
        end
        checks++;
        if (hi_cnt[0] !== 6) begin
            errors++;
            $display("FAIL presc_drop_high: got %0d expected 6", hi_cnt[0]);
        end
        measure(-1, 2'd0, '0, -1, '0);
        checks++;
        if (per_len !== 16) begin
            errors++;
            $display("FAIL presc_zero_period: got %0d expected 16", per_len);
        end
    endtask

    task automatic test_run_stop();
        int bad = 0;
        repeat (3) step();
        checks++;
        if (pwm_out !== 4'b1011) begin
            errors++;
            $display("FAIL run_before_stop: got %b expected 1011", pwm_out);
        end
        run = 1'b0;
        step();
        checks++;
        if (pwm_out !== 4'b0000 || enable !== 1'b0) begin
            errors++;
            $display("FAIL run_stop: got pwm=%b en=%b expected pwm=0000 en=0", pwm_out, enable);
        end
        write_duty(2'd0, 4'd2);
        for (int k = 0; k < 20; k++) begin
            if (pwm_out !== 4'b0000 || enable !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL run_idle: got %0d active samples expected 0", bad);
        end
        run = 1'b1;
        step();
        checks++;
        if (pwm_out !== 4'b1011) begin
            errors++;
            $display("FAIL run_restart: got %b expected 1011", pwm_out);
        end
        measure(-1, 2'd0, '0, -1, '0);
        checks++;
        if (per_len !== 16) begin
            errors++;
            $display("FAIL run_first_period: got %0d expected 16", per_len);
        end
        checks++;
        if (hi_cnt[0] !== 2) begin
            errors++;
            $display("FAIL run_new_duty: got %0d expected 2", hi_cnt[0]);
        end
    endtask

    task automatic test_async_reset();
        repeat (3) step();
        checks++;
        if (pwm_out !== 4'b1010) begin
            errors++;
            $display("FAIL areset_before: got %b expected 1010", pwm_out);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (pwm_out !== 4'b0000 || enable !== 1'b0) begin
            errors++;
            $display("FAIL areset_async: got pwm=%b en=%b expected pwm=0000 en=0", pwm_out, enable);
        end
        repeat (2) step();
        reset = 1'b1;
        step();
        measure(-1, 2'd0, '0, -1, '0);
        checks++;
        if (per_len !== 16) begin
            errors++;
            $display("FAIL areset_resume: got %0d expected 16", per_len);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (hi_cnt[i] !== 0) begin
                errors++;
                $display("FAIL areset_duty ch%0d: got %0d expected 0", i, hi_cnt[i]);
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        run      = 1'b1;
        mode     = 1'b0;
        prescale = '0;
        wr_en    = 1'b0;
        wr_ch    = '0;
        wr_duty  = '0;
        test_reset();
        test_edge();
        test_double_buffer();
        test_back_to_back();
        test_center();
        test_prescale();
        test_run_stop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
